// File: rtl/avalon_gpio_out_multi_pkg.sv
// Shared constants and types for the multi-bit Avalon-MM output GPIO.
package gpio_out_pkg;

    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_SET   = 3'd1;
    localparam logic [2:0] ADDR_CLR   = 3'd2;
    localparam logic [2:0] ADDR_TGL   = 3'd3;
    localparam logic [2:0] ADDR_PLEN  = 3'd4;
    localparam logic [2:0] ADDR_PULSE = 3'd5;

    localparam int BUSY_BIT = 31;

    typedef enum logic {
        IDLE,
        ACTIVE
    } pulse_state_t;

endpackage

// File: rtl/avalon_gpio_out_multi_if.sv
// Avalon-MM slave bus bundle for the output GPIO.
interface avalon_gpio_out_multi_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/avalon_gpio_out_multi_pulse_timer.sv
// Timed-pulse engine: holds the pulse length, the active mask and the countdown.
module gpio_pulse_timer
    import gpio_out_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PULSE_CNT_W = 16,
    parameter int WD_W        = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   arm,
    input  logic                   plen_wr,
    input  logic [WD_W-1:0]        wd,
    output logic                   busy,
    output logic [WIDTH-1:0]       mask,
    output logic [PULSE_CNT_W-1:0] plen
);

    pulse_state_t           state, state_nxt;
    logic [PULSE_CNT_W-1:0] cnt, cnt_nxt;
    logic [PULSE_CNT_W-1:0] plen_nxt;
    logic [WIDTH-1:0]       mask_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            plen  <= PULSE_CNT_W'(1);
            mask  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            plen  <= plen_nxt;
            mask  <= mask_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        plen_nxt  = plen;
        mask_nxt  = mask;
        // A zero length would never terminate, so it is stored as one
        if (plen_wr) begin
            if (wd[PULSE_CNT_W-1:0] == '0)
                plen_nxt = PULSE_CNT_W'(1);
            else
                plen_nxt = wd[PULSE_CNT_W-1:0];
        end
        unique case (state)
            IDLE: begin
                if (arm && (wd[WIDTH-1:0] != '0)) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = plen;
                    mask_nxt  = wd[WIDTH-1:0];
                end
            end
            ACTIVE: begin
                cnt_nxt = cnt - PULSE_CNT_W'(1);
                if (cnt == PULSE_CNT_W'(1)) begin
                    state_nxt = IDLE;
                    mask_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == ACTIVE);

endmodule

// File: rtl/avalon_gpio_out_multi.sv
// Avalon-MM WIDTH-bit output GPIO with set/clear/toggle registers.
// Define GPIO_OUT_PULSE_EN to build the timed-pulse engine (addresses 4, 5).
module avalon_gpio_out_multi
    import gpio_out_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PULSE_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    avalon_gpio_out_multi_if.slave    bus,
    output logic [WIDTH-1:0]          out_port,
    output logic                      pulse_busy
);

    localparam int WD_W = (WIDTH > PULSE_CNT_W) ? WIDTH : PULSE_CNT_W;

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q, data_nxt;
    logic [31:0]      rd;
    logic             unused_wd;

    assign wr        = bus.chipselect && !bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign unused_wd = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            data_q <= RESET_VALUE;
        else
            data_q <= data_nxt;
    end

    always_comb begin
        data_nxt = data_q;
        if (wr) begin
            unique case (bus.address)
                ADDR_DATA: data_nxt = wd;
                ADDR_SET:  data_nxt = data_q | wd;
                ADDR_CLR:  data_nxt = data_q & ~wd;
                ADDR_TGL:  data_nxt = data_q ^ wd;
                default:   data_nxt = data_q;
            endcase
        end
    end

`ifdef GPIO_OUT_PULSE_EN
    logic                   busy;
    logic [WIDTH-1:0]       mask;
    logic [PULSE_CNT_W-1:0] plen;

    gpio_pulse_timer #(
        .WIDTH       (WIDTH),
        .PULSE_CNT_W (PULSE_CNT_W),
        .WD_W        (WD_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .arm     (wr && (bus.address == ADDR_PULSE)),
        .plen_wr (wr && (bus.address == ADDR_PLEN)),
        .wd      (bus.writedata[WD_W-1:0]),
        .busy    (busy),
        .mask    (mask),
        .plen    (plen)
    );

    // Mask is cleared when the pulse ends, so the XOR reverts with busy
    assign out_port   = data_q ^ (busy ? mask : '0);
    assign pulse_busy = busy;

    always_comb begin
        rd = '0;
        unique case (bus.address)
            ADDR_DATA:  rd[WIDTH-1:0] = data_q;
            ADDR_PLEN:  rd[PULSE_CNT_W-1:0] = plen;
            ADDR_PULSE: begin
                rd[WIDTH-1:0] = mask;
                rd[BUSY_BIT]  = busy;
            end
            default:    rd = '0;
        endcase
    end
`else
    assign out_port   = data_q;
    assign pulse_busy = 1'b0;

    always_comb begin
        rd = '0;
        if (bus.address == ADDR_DATA)
            rd[WIDTH-1:0] = data_q;
    end
`endif

    assign bus.readdata = rd;

endmodule

// File: tb/tb_avalon_gpio_out_multi.sv
// Scoreboard bench for avalon_gpio_out_multi (WIDTH=8, RESET_VALUE=8'hA5).
module tb_avalon_gpio_out_multi;

    typedef struct {
        int          when;
        string       name;
        logic [7:0]  eo;
        logic        eb;
        logic [31:0] er;
        bit          chk_rd;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [7:0] out_port;
    logic       pulse_busy;

    exp_t q[$];
    int   ncyc;
    int   tests;
    int   fails;

    avalon_gpio_out_multi_if bus ();

    avalon_gpio_out_multi #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .PULSE_CNT_W (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .out_port   (out_port),
        .pulse_busy (pulse_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares the queued expectation belonging to each cycle
    always @(negedge clk) begin
        exp_t e;
        ncyc = ncyc + 1;
        while (q.size() > 0 && q[0].when <= ncyc) begin
            e = q.pop_front();
            if (e.when < ncyc) begin
                tests++;
                fails++;
                $display("FAIL %s: expectation missed its cycle (%0d < %0d)",
                         e.name, e.when, ncyc);
            end else begin
                tests++;
                if (out_port !== e.eo) begin
                    fails++;
                    $display("FAIL %s out_port: got %h want %h",
                             e.name, out_port, e.eo);
                end
                tests++;
                if (pulse_busy !== e.eb) begin
                    fails++;
                    $display("FAIL %s pulse_busy: got %b want %b",
                             e.name, pulse_busy, e.eb);
                end
                if (e.chk_rd) begin
                    tests++;
                    if (bus.readdata !== e.er) begin
                        fails++;
                        $display("FAIL %s readdata: got %h want %h",
                                 e.name, bus.readdata, e.er);
                    end
                end
            end
        end
    end

    // One bus cycle: drive, queue what this cycle must show, advance
    task automatic step(input string name, input logic [2:0] a,
                        input bit w, input logic [31:0] d,
                        input logic [7:0] eo, input logic eb,
                        input bit chk, input logic [31:0] er);
        exp_t e;
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = !w;
        bus.writedata  = d;
        e.when   = ncyc + 1;
        e.name   = name;
        e.eo     = eo;
        e.eb     = eb;
        e.er     = er;
        e.chk_rd = chk;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    initial begin
        ncyc  = 0;
        tests = 0;
        fails = 0;
        reset_n        = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        step("rst_data", 3'd0, 0, 0, 8'hA5, 0, 1, 32'h0000_00A5);
`ifdef GPIO_OUT_PULSE_EN
        step("rst_plen", 3'd4, 0, 0, 8'hA5, 0, 1, 32'h1);
`else
        step("rst_plen", 3'd4, 0, 0, 8'hA5, 0, 1, 32'h0);
`endif
        step("rst_pulse", 3'd5, 0, 0, 8'hA5, 0, 1, 32'h0);

        step("wr_data", 3'd0, 1, 32'h0F, 8'hA5, 0, 0, 0);
        step("wr_set", 3'd1, 1, 32'hF0, 8'h0F, 0, 0, 0);
        step("wr_clr", 3'd2, 1, 32'h03, 8'hFF, 0, 0, 0);
        step("wr_tgl", 3'd3, 1, 32'h81, 8'hFC, 0, 0, 0);
        step("rd_data", 3'd0, 0, 0, 8'h7D, 0, 1, 32'h7D);
        step("rd_set", 3'd1, 0, 0, 8'h7D, 0, 1, 32'h0);
        step("rd_clr", 3'd2, 0, 0, 8'h7D, 0, 1, 32'h0);
        step("rd_tgl", 3'd3, 0, 0, 8'h7D, 0, 1, 32'h0);
        step("wr_rsv6", 3'd6, 1, 32'hFF, 8'h7D, 0, 1, 32'h0);
        step("rd_rsv7", 3'd7, 0, 0, 8'h7D, 0, 1, 32'h0);
        step("wr_hi", 3'd0, 1, 32'hFFFF_FF00, 8'h7D, 0, 0, 0);
        step("rd_hi", 3'd0, 0, 0, 8'h00, 0, 1, 32'h0);

`ifdef GPIO_OUT_PULSE_EN
        step("wr_plen5", 3'd4, 1, 32'd5, 8'h00, 0, 0, 0);
        step("rd_plen5", 3'd4, 0, 0, 8'h00, 0, 1, 32'd5);
        step("arm_p1", 3'd5, 1, 32'h01, 8'h00, 0, 0, 0);
        step("p1_c1_rearm", 3'd5, 1, 32'h02, 8'h01, 1, 0, 0);
        step("p1_c2_set", 3'd1, 1, 32'h01, 8'h01, 1, 0, 0);
        step("p1_c3", 3'd5, 0, 0, 8'h00, 1, 1, 32'h8000_0001);
        step("p1_c4", 3'd5, 0, 0, 8'h00, 1, 1, 32'h8000_0001);
        step("p1_c5", 3'd5, 0, 0, 8'h00, 1, 1, 32'h8000_0001);
        step("p1_end", 3'd5, 0, 0, 8'h01, 0, 1, 32'h0);

        step("wr_plen0", 3'd4, 1, 32'd0, 8'h01, 0, 0, 0);
        step("rd_plen0", 3'd4, 0, 0, 8'h01, 0, 1, 32'd1);
        step("arm_p2", 3'd5, 1, 32'h80, 8'h01, 0, 0, 0);
        step("p2_c1", 3'd0, 0, 0, 8'h81, 1, 1, 32'h01);
        step("p2_end", 3'd0, 0, 0, 8'h01, 0, 1, 32'h01);

        step("wr_plen10", 3'd4, 1, 32'd10, 8'h01, 0, 0, 0);
        step("arm_p3", 3'd5, 1, 32'h01, 8'h01, 0, 0, 0);
        step("p3_c1", 3'd0, 0, 0, 8'h00, 1, 1, 32'h01);
        reset_n = 1'b0;
        step("p3_rst", 3'd5, 0, 0, 8'hA5, 0, 1, 32'h0);
        reset_n = 1'b1;
        step("post_rst_plen", 3'd4, 0, 0, 8'hA5, 0, 1, 32'h1);
        step("post_rst_idle", 3'd5, 0, 0, 8'hA5, 0, 1, 32'h0);
`else
        step("wr_plen_rsv", 3'd4, 1, 32'd5, 8'h00, 0, 0, 0);
        step("rd_plen_rsv", 3'd4, 0, 0, 8'h00, 0, 1, 32'h0);
        step("wr_pulse_rsv", 3'd5, 1, 32'h01, 8'h00, 0, 0, 0);
        step("rd_pulse_rsv", 3'd5, 0, 0, 8'h00, 0, 1, 32'h0);
        step("no_pulse", 3'd0, 0, 0, 8'h00, 0, 1, 32'h0);
`endif

        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(posedge clk);
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations never checked, want 0",
                     q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
